// File: rtl/addsub_bist_pkg.sv
// Shared types, constants and the golden add/sub model for the adder BIST.
package addsub_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Galois feedback taps (x^16 + x^14 + x^13 + x^11 + 1), right-shifting form.
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  // Directed corner vectors applied before the pseudo-random ones.
  localparam int NUM_CORNERS = 4;
  localparam logic [15:0] CORNER_A  [NUM_CORNERS] = '{16'h0000, 16'hFFFF, 16'h0000, 16'h8000};
  localparam logic [15:0] CORNER_B  [NUM_CORNERS] = '{16'h0000, 16'h0001, 16'h0001, 16'h8000};
  localparam logic        CORNER_OP [NUM_CORNERS] = '{1'b0, 1'b0, 1'b1, 1'b0};

  // Widest operand the golden model accepts.
  localparam int GOLD_MAX_W = 64;

  // Returns {Co,S} in the low width+1 bits; subtract is A + ~B + 1 so Co=1 means no borrow.
  function automatic logic [GOLD_MAX_W:0] golden_addsub(
    input logic [GOLD_MAX_W-1:0] a,
    input logic [GOLD_MAX_W-1:0] b,
    input logic                  op,
    input int                    width
  );
    logic [GOLD_MAX_W-1:0] mask;
    logic [GOLD_MAX_W-1:0] b_eff;
    mask  = (width >= GOLD_MAX_W) ? '1 : ((GOLD_MAX_W'(1) << width) - GOLD_MAX_W'(1));
    b_eff = op ? (~b & mask) : (b & mask);
    return {1'b0, a & mask} + {1'b0, b_eff} + (GOLD_MAX_W + 1)'(op);
  endfunction

endpackage

// File: rtl/addsub_bist_lfsr.sv
// 16-bit Galois LFSR with seed load and step enable; exposes the current and one-step-ahead value.
module bist_lfsr
  import addsub_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value,
  output logic [15:0] value_stepped
);

  logic [15:0] state_reg;

  assign value         = state_reg;
  assign value_stepped = {1'b0, state_reg[15:1]} ^ (state_reg[0] ? LFSR_POLY : 16'h0000);

  // Seed load wins over stepping; reset value is nonzero so the register never locks up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= 16'h0001;
    end else if (load) begin
      state_reg <= seed;
    end else if (step) begin
      state_reg <= value_stepped;
    end
  end

endmodule

// File: rtl/addsub_bist.sv
// BIST controller: drives the ripple-carry add/sub unit, checks every response and records the first failure.
module addsub_bist
  import addsub_bist_pkg::*;
#(
  parameter int          WIDTH         = 16,
  parameter int          NUM_VECTORS   = 256,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      fail_idx,
  output logic [WIDTH-1:0] fail_A,
  output logic [WIDTH-1:0] fail_B,
  output logic             fail_op,
  output logic [WIDTH-1:0] dut_A,
  output logic [WIDTH-1:0] dut_B,
  output logic             dut_add_sub,
  input  logic [WIDTH-1:0] dut_S,
  input  logic             dut_Co
);

  localparam int               CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [15:0]      LAST_IDX    = 16'(NUM_VECTORS - 1);
  localparam logic [15:0]      SEED_EFF    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] settle_cnt_reg;
  logic [15:0]      idx_reg, idx_next;
  logic [WIDTH-1:0] dut_a_reg, dut_b_reg;
  logic             dut_op_reg;
  logic [15:0]      err_count_reg, fail_idx_reg;
  logic [WIDTH-1:0] fail_a_reg, fail_b_reg;
  logic             fail_op_reg;

  logic             start_run, settle_last, in_check, last_vec, lfsr_step;
  logic [WIDTH-1:0] vec_a_next, vec_b_next;
  logic             vec_op_next;
  logic [15:0]      lfsr_value, lfsr_stepped;
  logic [WIDTH:0]   gold;
  logic             mismatch;

  // Corner constants adapted to the operand width (sign-extended or truncated).
  logic [WIDTH-1:0] corner_a [NUM_CORNERS];
  logic [WIDTH-1:0] corner_b [NUM_CORNERS];
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORNERS; gi++) begin : g_corner
      assign corner_a[gi] = WIDTH'($signed(CORNER_A[gi]));
      assign corner_b[gi] = WIDTH'($signed(CORNER_B[gi]));
    end
  endgenerate

  assign settle_last = (state_reg == SETTLE) && (settle_cnt_reg == '0);
  assign in_check    = (state_reg == CHECK);
  assign last_vec    = (idx_reg == LAST_IDX);
  // The LFSR only advances while producing random vectors: the pair for vector idx+1
  // comes from steps in the last settle cycle and the check cycle of vector idx (idx>=3).
  assign lfsr_step   = (idx_reg >= 16'(NUM_CORNERS - 1)) && (settle_last || in_check);

  bist_lfsr u_lfsr (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (start_run),
    .step          (lfsr_step),
    .seed          (SEED_EFF),
    .value         (lfsr_value),
    .value_stepped (lfsr_stepped)
  );

  assign gold     = (WIDTH + 1)'(golden_addsub(GOLD_MAX_W'(dut_a_reg), GOLD_MAX_W'(dut_b_reg),
                                               dut_op_reg, WIDTH));
  assign mismatch = ({dut_Co, dut_S} != gold);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; start is only honoured while idle or done.
  always_comb begin
    state_next = state_reg;
    start_run  = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = SETTLE;
          start_run  = 1'b1;
        end
      end
      SETTLE:  if (settle_cnt_reg == '0) state_next = CHECK;
      CHECK:   state_next = last_vec ? DONE : SETTLE;
      default: state_next = IDLE;
    endcase
  end

  // Vector that follows the current one: a corner, or the LFSR pair with op = idx[0].
  always_comb begin
    idx_next    = idx_reg + 16'd1;
    vec_a_next  = WIDTH'(lfsr_value);
    vec_b_next  = WIDTH'(lfsr_stepped);
    vec_op_next = idx_next[0];
    if (idx_next < 16'(NUM_CORNERS)) begin
      vec_a_next  = corner_a[idx_next[1:0]];
      vec_b_next  = corner_b[idx_next[1:0]];
      vec_op_next = CORNER_OP[idx_next[1:0]];
    end
  end

  // Run datapath: vector registers, settle counter, error count and first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt_reg <= '0;
      idx_reg        <= '0;
      dut_a_reg      <= '0;
      dut_b_reg      <= '0;
      dut_op_reg     <= 1'b0;
      err_count_reg  <= '0;
      fail_idx_reg   <= '0;
      fail_a_reg     <= '0;
      fail_b_reg     <= '0;
      fail_op_reg    <= 1'b0;
    end else if (start_run) begin
      settle_cnt_reg <= SETTLE_INIT;
      idx_reg        <= '0;
      dut_a_reg      <= corner_a[0];
      dut_b_reg      <= corner_b[0];
      dut_op_reg     <= CORNER_OP[0];
      err_count_reg  <= '0;
      fail_idx_reg   <= '0;
      fail_a_reg     <= '0;
      fail_b_reg     <= '0;
      fail_op_reg    <= 1'b0;
    end else begin
      if ((state_reg == SETTLE) && (settle_cnt_reg != '0)) begin
        settle_cnt_reg <= settle_cnt_reg - CNT_W'(1);
      end
      if (in_check) begin
        if (mismatch) begin
          if (err_count_reg != 16'hFFFF) err_count_reg <= err_count_reg + 16'd1;
          if (err_count_reg == 16'h0000) begin
            fail_idx_reg <= idx_reg;
            fail_a_reg   <= dut_a_reg;
            fail_b_reg   <= dut_b_reg;
            fail_op_reg  <= dut_op_reg;
          end
        end
        if (!last_vec) begin
          idx_reg        <= idx_next;
          settle_cnt_reg <= SETTLE_INIT;
          dut_a_reg      <= vec_a_next;
          dut_b_reg      <= vec_b_next;
          dut_op_reg     <= vec_op_next;
        end
      end
    end
  end

  assign busy        = (state_reg == SETTLE) || (state_reg == CHECK);
  assign done        = (state_reg == DONE);
  assign pass        = done && (err_count_reg == 16'h0000);
  assign err_count   = err_count_reg;
  assign fail_idx    = fail_idx_reg;
  assign fail_A      = fail_a_reg;
  assign fail_B      = fail_b_reg;
  assign fail_op     = fail_op_reg;
  assign dut_A       = dut_a_reg;
  assign dut_B       = dut_b_reg;
  assign dut_add_sub = dut_op_reg;

endmodule

// File: tb/tb_addsub_bist.sv
// Scoreboard bench: a behavioural adder (with selectable faults) feeds the BIST; each run's
// expected outcome is queued at start and checked by a monitor when done rises.
`timescale 1ns/1ps
module tb_addsub_bist;

  localparam int          W         = 16;
  localparam int          NV        = 256;
  localparam int          SC        = 2;
  localparam logic [15:0] SEED      = 16'hACE1;
  localparam int          RUN_EDGES = NV * (SC + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass, fail_op, dut_add_sub, dut_Co;
  logic [15:0]   err_count, fail_idx;
  logic [W-1:0]  fail_A, fail_B, dut_A, dut_B, dut_S;
  logic [16:0]   adder_res;

  int fault_mode = 0;
  int fault_bit  = 0;
  int cyc        = 0;
  int n_cmp      = 0;
  int n_bad      = 0;

  typedef struct {
    int          start_cyc;
    int          errs;
    int          fidx;
    logic [15:0] fa;
    logic [15:0] fb;
    logic        fop;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  addsub_bist #(.WIDTH(W), .NUM_VECTORS(NV), .SETTLE_CYCLES(SC), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_idx(fail_idx), .fail_A(fail_A), .fail_B(fail_B),
    .fail_op(fail_op), .dut_A(dut_A), .dut_B(dut_B), .dut_add_sub(dut_add_sub),
    .dut_S(dut_S), .dut_Co(dut_Co)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Plain arithmetic: subtract yields 2^16 + A - B, so bit 16 is set exactly when no borrow occurs.
  function automatic logic [16:0] golden(input logic [15:0] a, input logic [15:0] b, input logic op);
    int unsigned r;
    if (op) r = 32'(a) + 32'd65536 - 32'(b);
    else    r = 32'(a) + 32'(b);
    return r[16:0];
  endfunction

  function automatic logic [16:0] adder_model(input int mode, input int bitn,
                                              input logic [15:0] a, input logic [15:0] b, input logic op);
    logic [16:0] r;
    r = golden(a, b, op);
    case (mode)
      1: r[15] = 1'b0;
      2: r[16] = 1'b0;
      3: r = 17'(a) + 17'(b) + 17'(op);
      4: r[bitn] = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  always_comb adder_res = adder_model(fault_mode, fault_bit, dut_A, dut_B, dut_add_sub);
  assign dut_S  = adder_res[15:0];
  assign dut_Co = adder_res[16];

  // Whole-run reference: enumerate the vector list and tally what the faulty adder gets wrong.
  function automatic exp_t ref_run(input int mode, input int bitn, input int start_cyc);
    exp_t        e;
    logic [15:0] s, a, b;
    logic        op;
    e.start_cyc = start_cyc; e.errs = 0; e.fidx = 0; e.fa = 0; e.fb = 0; e.fop = 0;
    s = SEED;
    for (int i = 0; i < NV; i++) begin
      case (i)
        0: begin a = 16'h0000; b = 16'h0000; op = 1'b0; end
        1: begin a = 16'hFFFF; b = 16'h0001; op = 1'b0; end
        2: begin a = 16'h0000; b = 16'h0001; op = 1'b1; end
        3: begin a = 16'h8000; b = 16'h8000; op = 1'b0; end
        default: begin
          s = lfsr_step(s); a = s;
          s = lfsr_step(s); b = s;
          op = ((i % 2) == 1);
        end
      endcase
      if (adder_model(mode, bitn, a, b, op) != golden(a, b, op)) begin
        if (e.errs == 0) begin
          e.fidx = i; e.fa = a; e.fb = b; e.fop = op;
        end
        if (e.errs < 65535) e.errs++;
      end
    end
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Monitor: pops one expected run per rising done and compares the reported result.
  initial begin : monitor
    logic  done_prev;
    exp_t  e;
    string nm;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done_prev = 1'b0;
      end else begin
        if (done && !done_prev) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
          end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            $display("run %s: done after %0d edges, err_count=%0d pass=%0b fail_idx=%0d fail_A=%h fail_B=%h fail_op=%0b",
                     nm, cyc - e.start_cyc, err_count, pass, fail_idx, fail_A, fail_B, fail_op);
            check({nm, "_latency"},   32'(cyc - e.start_cyc), 32'(RUN_EDGES));
            check({nm, "_err_count"}, 32'(err_count),         32'(e.errs));
            check({nm, "_pass"},      32'(pass),              32'(e.errs == 0));
            check({nm, "_fail_idx"},  32'(fail_idx),          32'(e.fidx));
            check({nm, "_fail_A"},    32'(fail_A),            32'(e.fa));
            check({nm, "_fail_B"},    32'(fail_B),            32'(e.fb));
            check({nm, "_fail_op"},   32'(fail_op),           32'(e.fop));
          end
        end
        done_prev = done;
      end
    end
  end

  task automatic launch(input string nm, input int mode, input int bitn);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    @(negedge clk);
    fault_mode = mode;
    fault_bit  = bitn;
    start      = 1'b1;
    exp_q.push_back(ref_run(mode, bitn, cyc + 1));
    name_q.push_back(nm);
    @(negedge clk);
    start = 1'b0;
    check({nm, "_busy_after_start"}, 32'(busy), 32'd1);
    check({nm, "_done_after_start"}, 32'(done), 32'd0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < RUN_EDGES + 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("run_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_flags"},     32'({busy, done, pass, fail_op, dut_add_sub}), 32'd0);
    check({nm, "_err_count"}, 32'(err_count), 32'd0);
    check({nm, "_fail_idx"},  32'(fail_idx),  32'd0);
    check({nm, "_fail_AB"},   {fail_A, fail_B}, 32'd0);
    check({nm, "_dut_AB"},    {dut_A, dut_B},   32'd0);
  endtask

  initial begin : stimulus
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy_done", 32'({busy, done}), 32'd0);

    launch("correct", 0, 0);        wait_idle();
    launch("s15_stuck0", 1, 0);     wait_idle();
    launch("co_stuck0", 2, 0);      wait_idle();
    launch("no_b_invert", 3, 0);    wait_idle();
    for (int k = 0; k < 3; k++) begin
      launch("s_bit_stuck1", 4, int'($urandom_range(0, 15)));
      wait_idle();
    end

    // A second start mid-run must not restart the sequence.
    launch("start_ignored", 3, 0);
    repeat (98) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Asynchronous reset mid-run clears everything at once; the rerun matches a fresh run.
    launch("reset_mid", 2, 0);
    repeat (299) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    name_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    launch("after_reset", 2, 0);    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
